alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Multi-cycle RV32I execute unit.
- Consumes the 4-bit ALU selection code produced by the ALU control decode stage, plus two 32-bit operands, over a valid/ready handshake.
- Returns a 32-bit result and condition flags over a second valid/ready handshake.
- Shifts use an iterative 1-bit-per-cycle shifter; all other operations take one cycle.
- Sits in the EX stage of the pipelined core; stalls upstream via in_ready.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush; drops any operation in progress.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- alu_sel  in  4  operation code, using the `ALU_*` encoding in defines.v.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate); shamt = op_b[SHAMT_W-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- flag_z  out  1  result == 0.
- flag_c  out  1  carry out for ADD; no-borrow (op_a >= op_b unsigned) for SUB; 0 otherwise.
- flag_v  out  1  signed overflow for ADD/SUB; 0 otherwise.
- flag_n  out  1  result[XLEN-1].

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0; shift count=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture alu_sel, op_a, op_b.
  - Non-shift code: compute in the capture cycle, register result and flags, go to DONE. out_valid rises the next cycle (latency 1).
  - SLL/SRL/SRA with shamt!=0: load working register=op_a, count=shamt, go to SHIFT.
  - Shift with shamt==0: result=op_a, go directly to DONE.
- SHIFT:
  - in_ready=0.
  - Each cycle: shift working register by 1 (SLL inserts 0 at the LSB; SRL inserts 0 at the MSB; SRA replicates the MSB); count decrements.
  - When count reaches 1, perform the final shift and go to DONE.
  - Total latency from accept to out_valid = shamt cycles (minimum 1).
- DONE:
  - out_valid=1; result and flags held stable.
  - in_ready=0 (no accept-while-draining).
  - On out_ready, go to IDLE the next cycle; out_valid drops. Back-to-back throughput for non-shift ops is 1 operation per 2 cycles.
- Operations:
  - ADD/SUB: modulo 2^XLEN; carry/overflow computed from an XLEN+1-bit sum.
  - SLT: signed compare; SLTU: unsigned compare. Result is 0 or 1, zero-extended.
  - AND/OR/XOR: bitwise.
  - PASS and any undefined code: result=op_b, flags c/v=0.
- Flags flag_z and flag_n are computed from the final result for every operation, including shifts.
- flush:
  - Has priority over all handshakes: next state IDLE, out_valid=0, and any in-flight shift is discarded.
  - A request presented in the same cycle as flush is not accepted.
- rst asserted mid-shift or in DONE: immediate return to the reset values; the result is lost.
- alu_sel and operands are sampled only at accept; later changes are ignored.

Optional Feature:
- Macro: ALU_EXEC_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. Every operation goes IDLE->DONE with latency 1, the SHIFT state and counter are not built, and in_ready behaviour is unchanged.
- Undefined: iterative shifter as described under Behaviour.
- Result and flag values must be identical in both builds; only latency differs.

Decomposition:
- `ALU_*` operation codes, and the state encoding constants (IDLE/SHIFT/DONE), belong in defines.v.
- One natural sub-module: alu_shift_step, a combinational 1-bit shift with mode input (SLL/SRL/SRA). It is also reused as the building block of the barrel shifter when ALU_EXEC_FAST_SHIFT_EN is defined.

Test Plan:
- ADD, op_a=0x7FFFFFFF, op_b=1 -> one cycle later out_valid=1, result=0x80000000, v=1, n=1, c=0, z=0.
- SUB, op_a=5, op_b=5 -> result=0, z=1, c=1. SLTU, op_a=1, op_b=0xFFFFFFFF -> result=1. SLT with the same operands -> result=0.
- SRA, op_a=0x80000000, op_b=31 -> in_ready=0 for 31 cycles, then result=0xFFFFFFFF. SLL with op_b=0 -> latency 1, result=op_a.
- Output backpressure: hold out_ready=0 for 5 cycles after an XOR -> result and out_valid stay stable, in_ready stays 0. A new in_valid during this window is not accepted until the cycle after out_ready.
- Flush 3 cycles into SRL shamt=20 -> next cycle IDLE, out_valid never asserts. An immediately following ADD 2+3 -> result=5.
- Assert rst low mid-SHIFT, asynchronously between clock edges -> outputs return to reset values immediately. Re-run each test with ALU_EXEC_FAST_SHIFT_EN defined -> identical results, all latencies 1.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared types and operation codes for the RV32I execute unit.
// The ALU_* codes match the encoding produced by the ALU control decode stage.
package alu_exec_unit_pkg;

    localparam int unsigned ALU_XLEN    = 32;
    localparam int unsigned ALU_SHAMT_W = 5;
    localparam int unsigned ALU_SEL_W   = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_SEL_W-1:0] ALU_PASS = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
    } alu_flags_t;

    function automatic logic is_shift(input logic [ALU_SEL_W-1:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    function automatic shift_mode_e shift_mode(input logic [ALU_SEL_W-1:0] sel);
        shift_mode_e m;
        m = SH_SLL;
        if (sel == ALU_SRL) m = SH_SRL;
        if (sel == ALU_SRA) m = SH_SRA;
        return m;
    endfunction

endpackage

// File: rtl/alu_exec_unit_shift_step.sv
// Combinational single-bit shifter (logical left, logical right, arithmetic right).
module alu_shift_step
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned W = ALU_XLEN
) (
    input  logic [W-1:0] din,
    input  shift_mode_e  mode,
    output logic [W-1:0] dout_c
);

    always_comb begin
        dout_c = din;
        case (mode)
            SH_SLL:  dout_c = {din[W-2:0], 1'b0};
            SH_SRL:  dout_c = {1'b0, din[W-1:1]};
            SH_SRA:  dout_c = {din[W-1], din[W-1:1]};
            default: dout_c = din;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32I execute unit with valid/ready handshakes on both sides.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned XLEN    = ALU_XLEN,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [XLEN-1:0]      op_a,
    input  logic [XLEN-1:0]      op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 flag_n
);

    state_e           state, state_d;
    logic [XLEN-1:0]  result_d;
    alu_flags_t       flags_q, flags_d;
    logic [XLEN-1:0]  alu_res;
    logic             alu_c, alu_v;
    logic [XLEN:0]    sum_w, diff_w;
    logic [SHAMT_W-1:0] shamt;

    assign shamt  = op_b[SHAMT_W-1:0];
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;
    assign flag_n = flags_q.n;

    // Single-cycle operations; carry and overflow come from an XLEN+1-bit sum.
    always_comb begin
        sum_w   = {1'b0, op_a} + {1'b0, op_b};
        diff_w  = {1'b0, op_a} - {1'b0, op_b};
        alu_res = op_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                alu_res = sum_w[XLEN-1:0];
                alu_c   = sum_w[XLEN];
                alu_v   = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum_w[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SUB: begin
                alu_res = diff_w[XLEN-1:0];
                alu_c   = ~diff_w[XLEN];
                alu_v   = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff_w[XLEN-1] != op_a[XLEN-1]);
            end
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            default:  alu_res = op_b;
        endcase
    end

`ifdef ALU_EXEC_FAST_SHIFT_EN
    // Barrel shifter: a chain of single-bit steps, each enabled when its index is below shamt.
    shift_mode_e     sh_mode_c;
    logic [XLEN-1:0] stage      [XLEN];
    logic [XLEN-1:0] stage_step [XLEN-1];
    logic [XLEN-1:0] barrel_c;

    assign sh_mode_c = shift_mode(alu_sel);
    assign stage[0]  = op_a;
    assign barrel_c  = stage[XLEN-1];

    for (genvar i = 0; i < XLEN - 1; i++) begin : g_barrel
        alu_shift_step #(.W(XLEN)) u_step (
            .din    (stage[i]),
            .mode   (sh_mode_c),
            .dout_c (stage_step[i])
        );
        assign stage[i+1] = (SHAMT_W'(i) < shamt) ? stage_step[i] : stage[i];
    end
`else
    shift_mode_e        mode_q, mode_d, step_mode;
    logic [XLEN-1:0]    work_q, work_d, step_in, step_c;
    logic [SHAMT_W-1:0] count_q, count_d;

    // The first shift happens in the accept cycle, so latency equals shamt.
    assign step_in   = (state == SHIFT) ? work_q : op_a;
    assign step_mode = (state == SHIFT) ? mode_q : shift_mode(alu_sel);

    alu_shift_step #(.W(XLEN)) u_step (
        .din    (step_in),
        .mode   (step_mode),
        .dout_c (step_c)
    );
`endif

    always_comb begin
        state_d   = state;
        result_d  = result;
        flags_d   = flags_q;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        work_d    = work_q;
        count_d   = count_q;
        mode_d    = mode_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid && !flush) begin
                    state_d = DONE;
                    if (is_shift(alu_sel)) begin
                        flags_d.c = 1'b0;
                        flags_d.v = 1'b0;
`ifdef ALU_EXEC_FAST_SHIFT_EN
                        result_d = barrel_c;
`else
                        if (shamt == '0) begin
                            result_d = op_a;
                        end else if (shamt == SHAMT_W'(1)) begin
                            result_d = step_c;
                        end else begin
                            work_d  = step_c;
                            count_d = shamt - SHAMT_W'(1);
                            mode_d  = shift_mode(alu_sel);
                            state_d = SHIFT;
                        end
`endif
                    end else begin
                        result_d  = alu_res;
                        flags_d.c = alu_c;
                        flags_d.v = alu_v;
                    end
                end
            end
`ifndef ALU_EXEC_FAST_SHIFT_EN
            SHIFT: begin
                if (count_q == SHAMT_W'(1)) begin
                    result_d = step_c;
                    count_d  = '0;
                    state_d  = DONE;
                end else begin
                    work_d  = step_c;
                    count_d = count_q - SHAMT_W'(1);
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush discards whatever is in flight and keeps the last delivered result.
        if (flush) begin
            state_d  = IDLE;
            result_d = result;
            flags_d  = flags_q;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            count_d  = '0;
`endif
        end

        flags_d.z = (result_d == '0);
        flags_d.n = result_d[XLEN-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags_q   <= '0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            work_q    <= '0;
            count_q   <= '0;
            mode_q    <= SH_SLL;
`endif
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            result    <= result_d;
            flags_q   <= flags_d;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            work_q    <= work_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table through a scoreboard plus corner sequences.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_z, flag_c, flag_v, flag_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  zcvn;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  zcvn;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[19];

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] sel, input logic [31:0] b);
        int l;
        l = 1;
        if ((sel == ALU_SLL || sel == ALU_SRL || sel == ALU_SRA) && (b[4:0] > 5'd1))
            l = int'(b[4:0]);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        l = 1;
`endif
        return l;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Drive one operation, push its expectation, and compare when out_valid appears.
    task automatic do_op(input string name, input vec_t v);
        exp_t e;
        int   lat;
        wait_ready();
        in_valid = 1'b1;
        alu_sel  = v.sel;
        op_a     = v.a;
        op_b     = v.b;
        e.res  = v.res;
        e.zcvn = v.zcvn;
        e.lat  = exp_lat(v.sel, v.b);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_sel  = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check({name, "_out_timeout"}, 32'(out_valid), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check({name, "_lat"}, 32'(lat), 32'(e.lat));
            check({name, "_res"}, result, e.res);
            check({name, "_zcvn"}, {28'd0, flag_z, flag_c, flag_v, flag_n}, {28'd0, e.zcvn});
        end
    endtask

    initial begin
        int seen;
        logic [31:0] held;
        vec_t v;

        //              sel        a             b             result        zcvn
        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
        vecs[1]  = '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b1100};
        vecs[2]  = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0000};
        vecs[3]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        vecs[4]  = '{ALU_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0001};
        vecs[5]  = '{ALU_SLL,  32'h12345678, 32'h00000000, 32'h12345678, 4'b0000};
        vecs[6]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
        vecs[7]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0001};
        vecs[8]  = '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110};
        vecs[9]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001};
        vecs[10] = '{ALU_OR,   32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
        vecs[11] = '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 4'b0000};
        vecs[12] = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 4'b0000};
        vecs[13] = '{ALU_SLL,  32'h00000003, 32'h00000001, 32'h00000006, 4'b0000};
        vecs[14] = '{ALU_SRA,  32'h40000000, 32'h00000003, 32'h08000000, 4'b0000};
        vecs[15] = '{ALU_PASS, 32'h00001234, 32'hCAFEBABE, 32'hCAFEBABE, 4'b0001};
        vecs[16] = '{4'hF,     32'h00001234, 32'h00000000, 32'h00000000, 4'b1000};
        vecs[17] = '{ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 4'b0001};
        vecs[18] = '{ALU_SRL,  32'hFFFFFFFF, 32'h00000020, 32'hFFFFFFFF, 4'b0001};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_sel = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) do_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held, no accept until the cycle after out_ready.
        wait_ready();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_sel = ALU_XOR; op_a = 32'h0F0F0F0F; op_b = 32'hFFFF0000;
        @(posedge clk); #1;
        alu_sel = ALU_ADD; op_a = 32'd2; op_b = 32'd3;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'hF0F00F0F);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_drain_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_result", result, 32'd5);

        // Flush three cycles into a long shift (or while parked in DONE for the fast build).
        wait_ready();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_sel = ALU_SRL; op_a = 32'hFFFFFFFF; op_b = 32'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_never_valid", 32'(seen), 32'd0);

        // A request coincident with flush is dropped.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 32'd7; op_b = 32'd7;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_req_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("flush_req_valid", 32'(out_valid), 32'd0);
        v = '{ALU_ADD, 32'd2, 32'd3, 32'd5, 4'b0000};
        do_op("post_flush_add", v);

        // Asynchronous reset between clock edges during a shift.
        wait_ready();
        out_ready = 1'b0;
        in_valid = 1'b1; alu_sel = ALU_SRA; op_a = 32'h80000000; op_b = 32'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        held = result;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_flags", {28'd0, flag_z, flag_c, flag_v, flag_n}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        v = '{ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0101};
        do_op("post_rst_add", v);
        if (held == 32'hDEADBEEF) $display("note: held result %h", held);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
